// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// load_store_unit_pkg: load/store opcode, access size and helper functions. Rev 1.0
package load_store_unit_pkg;

  typedef enum logic [2:0] {
    LSU_LB  = 3'd0,
    LSU_LH  = 3'd1,
    LSU_LW  = 3'd2,
    LSU_LBU = 3'd3,
    LSU_LHU = 3'd4,
    LSU_SB  = 3'd5,
    LSU_SH  = 3'd6,
    LSU_SW  = 3'd7
  } lsu_op_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_t;

  function automatic logic is_load(lsu_op_t op);
    return (op == LSU_LB) || (op == LSU_LH) || (op == LSU_LW) ||
           (op == LSU_LBU) || (op == LSU_LHU);
  endfunction

  function automatic lsu_size_t op_size(lsu_op_t op);
    case (op)
      LSU_LB, LSU_LBU, LSU_SB: return SZ_B;
      LSU_LH, LSU_LHU, LSU_SH: return SZ_H;
      default:                 return SZ_W;
    endcase
  endfunction

  function automatic logic is_misaligned(lsu_op_t op, logic [1:0] offset);
    case (op_size(op))
      SZ_H:    return offset[0];
      SZ_W:    return offset != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// load_store_unit_if: req/gnt/rvalid data-memory port. Rev 1.0
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/load_store_unit_data_align.sv
`default_nettype none
// lsu_data_align: store lane replication/byte enables and load extract/extend. Rev 1.0
module lsu_data_align
  import load_store_unit_pkg::*;
(
  input  lsu_op_t     op,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_result
);

  logic [31:0] field;

  assign field = rdata >> {offset, 3'b000};

  always_comb begin
    be    = 4'b1111;
    wdata = store_data;
    case (op_size(op))
      SZ_B: begin
        be    = 4'b0001 << offset;
        wdata = {4{store_data[7:0]}};
      end
      SZ_H: begin
        be    = offset[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    load_result = field;
    case (op)
      LSU_LB:  load_result = {{24{field[7]}}, field[7:0]};
      LSU_LBU: load_result = {24'd0, field[7:0]};
      LSU_LH:  load_result = {{16{field[15]}}, field[15:0]};
      LSU_LHU: load_result = {16'd0, field[15:0]};
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// load_store_unit: RV32I memory-access stage, one load/store per command. Rev 1.0
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  lsu_op_t                 ls_op,
  input  logic [31:0]             addr,
  input  logic [31:0]             store_data,
  output logic                    busy,
  output logic                    done,
  output logic                    misaligned,
  output logic [31:0]             load_data,
  load_store_unit_if.master       mem
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t      state, state_d;
  lsu_op_t     op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic        done_d, mis_d, req_d, we_d;
  logic [31:0] load_d, addr_d, wdata_d;
  logic [3:0]  be_d;

  lsu_op_t     al_op;
  logic [1:0]  al_off;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_load;

  // In IDLE the aligner prepares lanes for the incoming command; otherwise it
  // works on the latched command to extract the returning read data.
  assign al_op  = (state == IDLE) ? ls_op : op_q;
  assign al_off = (state == IDLE) ? addr[1:0] : off_q;

  lsu_data_align u_align (
    .op          (al_op),
    .offset      (al_off),
    .store_data  (store_data),
    .rdata       (mem.mem_rdata),
    .be          (al_be),
    .wdata       (al_wdata),
    .load_result (al_load)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      op_q          <= LSU_LB;
      off_q         <= 2'b00;
      done          <= 1'b0;
      misaligned    <= 1'b0;
      load_data     <= 32'd0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= 32'd0;
      mem.mem_be    <= 4'd0;
      mem.mem_wdata <= 32'd0;
    end else begin
      state         <= state_d;
      op_q          <= op_d;
      off_q         <= off_d;
      done          <= done_d;
      misaligned    <= mis_d;
      load_data     <= load_d;
      mem.mem_req   <= req_d;
      mem.mem_we    <= we_d;
      mem.mem_addr  <= addr_d;
      mem.mem_be    <= be_d;
      mem.mem_wdata <= wdata_d;
    end
  end

  always_comb begin
    state_d = state;
    op_d    = op_q;
    off_d   = off_q;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    load_d  = load_data;
    req_d   = mem.mem_req;
    we_d    = mem.mem_we;
    addr_d  = mem.mem_addr;
    be_d    = mem.mem_be;
    wdata_d = mem.mem_wdata;
    case (state)
      IDLE: begin
        if (start) begin
          if (is_misaligned(ls_op, addr[1:0])) begin
            done_d = 1'b1;
            mis_d  = 1'b1;
          end else begin
            state_d = REQ;
            op_d    = ls_op;
            off_d   = addr[1:0];
            req_d   = 1'b1;
            we_d    = !is_load(ls_op);
            addr_d  = {addr[31:2], 2'b00};
            be_d    = al_be;
            wdata_d = al_wdata;
          end
        end
      end
      REQ: begin
        if (mem.mem_gnt) begin
          req_d = 1'b0;
          we_d  = 1'b0;
          if (is_load(op_q)) begin
            state_d = WAIT;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      WAIT: begin
        if (mem.mem_rvalid) begin
          state_d = IDLE;
          load_d  = al_load;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
`default_nettype wire
